// File: rtl/wb_pkg.sv
// wb_pkg: shared types and widths for the writeback arbiter.
package wb_pkg;
  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_FPU = 2'd1, SRC_MEM = 2'd2} src_t;
  localparam int REG_W = 5;
  localparam int XLEN_DEF = 32;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: three writeback sources in, one register-file write port out.
interface wb_arbiter_if #(parameter int XLEN = wb_pkg::XLEN_DEF);
  logic alu_valid, fpu_valid, mem_valid;
  logic alu_ready, fpu_ready, mem_ready;
  logic alu_fmode, fpu_fmode, mem_fmode;
  logic [wb_pkg::REG_W-1:0] alu_reg, fpu_reg, mem_reg;
  logic [XLEN-1:0] alu_data, fpu_data, mem_data;
  logic wenable, wfmode;
  logic [wb_pkg::REG_W-1:0] wreg;
  logic [XLEN-1:0] wdata;
  logic [1:0] wb_src;
  logic [15:0] stall_cnt;
  modport slave (
    input  alu_valid, fpu_valid, mem_valid, alu_fmode, fpu_fmode, mem_fmode,
           alu_reg, fpu_reg, mem_reg, alu_data, fpu_data, mem_data,
    output alu_ready, fpu_ready, mem_ready, wenable, wfmode, wreg, wdata, wb_src, stall_cnt
  );
  modport master (
    output alu_valid, fpu_valid, mem_valid, alu_fmode, fpu_fmode, mem_fmode,
           alu_reg, fpu_reg, mem_reg, alu_data, fpu_data, mem_data,
    input  alu_ready, fpu_ready, mem_ready, wenable, wfmode, wreg, wdata, wb_src, stall_cnt
  );
endinterface

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin grant; pointer advances past each winner.
module rr_arbiter3 import wb_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt
);
  src_t ptr;
  logic [2:0] r, f, raw;
  // rotate so the pointer's source sits at bit 0, pick first, rotate back
  always_comb begin
    r = ptr == SRC_FPU ? {req[0], req[2:1]} : ptr == SRC_MEM ? {req[1:0], req[2]} : req;
    f = r[0] ? 3'b001 : r[1] ? 3'b010 : {r[2], 2'b00};
    raw = ptr == SRC_FPU ? {f[1:0], f[2]} : ptr == SRC_MEM ? {f[0], f[2:1]} : f;
  end
  assign gnt = rst ? 3'b000 : raw;
  always_ff @(posedge clk) begin
    if (rst) ptr <= SRC_ALU;
    else if (gnt[0]) ptr <= SRC_FPU;
    else if (gnt[1]) ptr <= SRC_MEM;
    else if (gnt[2]) ptr <= SRC_ALU;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter with one-cycle registered write port.
module wb_arbiter import wb_pkg::*; #(
  parameter int DROP_ZERO = 1,
  parameter int XLEN = XLEN_DEF
) (
  input logic clk,
  input logic rst,
  wb_arbiter_if.slave bus
);
  logic [2:0] req, gnt;
  logic sel_fmode, wen_q, stall;
  logic [REG_W-1:0] sel_reg;
  logic [XLEN-1:0] sel_data;
  src_t sel_src;
  assign req = {bus.mem_valid, bus.fpu_valid, bus.alu_valid};
  rr_arbiter3 u_rr (.clk(clk), .rst(rst), .req(req), .gnt(gnt));
  assign bus.alu_ready = gnt[0];
  assign bus.fpu_ready = gnt[1];
  assign bus.mem_ready = gnt[2];
  always_comb begin
    sel_fmode = gnt[2] ? bus.mem_fmode : gnt[1] ? bus.fpu_fmode : bus.alu_fmode;
    sel_reg = gnt[2] ? bus.mem_reg : gnt[1] ? bus.fpu_reg : bus.alu_reg;
    sel_data = gnt[2] ? bus.mem_data : gnt[1] ? bus.fpu_data : bus.alu_data;
    sel_src = gnt[2] ? SRC_MEM : gnt[1] ? SRC_FPU : SRC_ALU;
    stall = $countones(req) > int'(|gnt);
  end
  // a write pending at the edge where reset arrives is suppressed, not issued
  assign bus.wenable = wen_q && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q <= 1'b0;
      bus.wfmode <= 1'b0;
      bus.wreg <= '0;
      bus.wdata <= '0;
      bus.wb_src <= SRC_ALU;
      bus.stall_cnt <= '0;
    end else begin
      wen_q <= |gnt && !(DROP_ZERO != 0 && !sel_fmode && sel_reg == '0);
      if (|gnt) begin
        bus.wfmode <= sel_fmode;
        bus.wreg <= sel_reg;
        bus.wdata <= sel_data;
        bus.wb_src <= sel_src;
      end
      if (stall && bus.stall_cnt != 16'hFFFF) bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors against hand-computed expectations.
module tb_wb_arbiter;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0;
  wb_arbiter_if bus ();
  wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rdy();
    return {bus.mem_ready, bus.fpu_ready, bus.alu_ready};
  endfunction

  initial begin
    {bus.alu_valid, bus.fpu_valid, bus.mem_valid} = '0;
    {bus.alu_fmode, bus.fpu_fmode, bus.mem_fmode} = '0;
    {bus.alu_reg, bus.fpu_reg, bus.mem_reg} = '0;
    {bus.alu_data, bus.fpu_data, bus.mem_data} = '0;
    tick(); tick();
    chk("rst_wen", bus.wenable, 0);
    chk("rst_wreg", bus.wreg, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_src", bus.wb_src, 0);
    chk("rst_stall", bus.stall_cnt, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_wen", bus.wenable, 0);
    chk("idle_rdy", rdy(), 0);
    chk("idle_stall", bus.stall_cnt, 0);

    bus.mem_valid = 1; bus.mem_fmode = 0; bus.mem_reg = 7; bus.mem_data = 32'hDEADBEEF;
    #1 chk("mem_rdy", rdy(), 3'b100);
    tick(); bus.mem_valid = 0;
    chk("mem_wen", bus.wenable, 1);
    chk("mem_fm", bus.wfmode, 0);
    chk("mem_reg", bus.wreg, 7);
    chk("mem_data", bus.wdata, 32'hDEADBEEF);
    chk("mem_src", bus.wb_src, 2);
    tick();
    chk("hold_wen", bus.wenable, 0);
    chk("hold_reg", bus.wreg, 7);
    chk("hold_src", bus.wb_src, 2);

    bus.alu_valid = 1; bus.alu_fmode = 0; bus.alu_reg = 0; bus.alu_data = 32'h1234;
    #1 chk("g0_rdy", rdy(), 3'b001);
    tick(); bus.alu_fmode = 1;
    chk("g0_drop", bus.wenable, 0);
    #1 chk("f0_rdy", rdy(), 3'b001);
    tick(); bus.alu_valid = 0;
    chk("f0_wen", bus.wenable, 1);
    chk("f0_fm", bus.wfmode, 1);
    chk("f0_reg", bus.wreg, 0);
    chk("f0_data", bus.wdata, 32'h1234);

    rst = 1; tick(); rst = 0;
    bus.alu_valid = 1; bus.fpu_valid = 1; bus.mem_valid = 1;
    bus.alu_fmode = 0; bus.fpu_fmode = 1; bus.mem_fmode = 0;
    bus.alu_reg = 1; bus.fpu_reg = 2; bus.mem_reg = 3;
    bus.alu_data = 32'hA0; bus.fpu_data = 32'hA1; bus.mem_data = 32'hA2;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("rr_rdy%0d", i), rdy(), 3'b001 << (i % 3));
      tick();
      chk($sformatf("rr_wen%0d", i), bus.wenable, 1);
      chk($sformatf("rr_src%0d", i), bus.wb_src, i % 3);
      chk($sformatf("rr_reg%0d", i), bus.wreg, i % 3 + 1);
      chk($sformatf("rr_data%0d", i), bus.wdata, 32'hA0 + i % 3);
      chk($sformatf("rr_stall%0d", i), bus.stall_cnt, i + 1);
    end

    bus.alu_valid = 0; bus.mem_valid = 0;
    #1 chk("fpu_rdy", rdy(), 3'b010);
    tick(); rst = 1; bus.fpu_valid = 0;
    #1 chk("rstN1_wen", bus.wenable, 0);
    chk("rstN1_rdy", rdy(), 0);
    tick(); rst = 0;
    chk("rstN2_wen", bus.wenable, 0);
    chk("rstN2_stall", bus.stall_cnt, 0);
    bus.alu_valid = 1; bus.fpu_valid = 1;
    #1 chk("post_rst_rdy", rdy(), 3'b001);

    for (int i = 0; i < 65534; i++) tick();
    chk("sat_pre", bus.stall_cnt, 16'hFFFE);
    tick();
    chk("sat_hit", bus.stall_cnt, 16'hFFFF);
    tick(); tick();
    chk("sat_hold", bus.stall_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
